// File: rtl/dmem_access_unit.sv
// Data-memory access unit: turns RV32 loads/stores into accesses on a word-wide,
// 1-cycle registered-read memory port, with sub-word read-modify-write and error checks.
module dmem_access_unit #(
  parameter int unsigned MEM_WORDS = 4096
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [2:0]  req_funct3,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        resp_valid,
  output logic [31:0] resp_rdata,
  output logic        resp_err,
  output logic [31:0] addr_d,
  input  logic [31:0] rdata,
  output logic        wen,
  output logic [31:0] wdata,
  output logic [2:0]  dbg_state_o
);

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    LD_RD   = 3'd1,
    LD_EXT  = 3'd2,
    RMW_RD  = 3'd3,
    RMW_MRG = 3'd4,
    WR      = 3'd5,
    ERR     = 3'd6
  } state_t;

  localparam logic [29:0] MEM_WORDS_W = 30'(MEM_WORDS);

  state_t      state_q, state_d;
  logic [31:0] addr_q, addr_nx;
  logic [31:0] wdata_q, wdata_nx;
  logic        wen_q, wen_nx;
  logic        resp_valid_q, resp_valid_nx;
  logic        resp_err_q, resp_err_nx;
  logic [31:0] resp_rdata_q, resp_rdata_nx;
  logic [2:0]  f3_q, f3_d;
  logic [15:0] st_q, st_d;
  logic        acc_err;
  logic [31:0] load_ext;
  logic [31:0] merged;

  // Handshake: a request transfers on a posedge with req_valid && req_ready; the
  // response is a one-cycle resp_valid pulse, and only one access is in flight.
  assign req_ready   = (state_q == IDLE);
  assign addr_d      = addr_q;
  assign wdata       = wdata_q;
  assign wen         = wen_q;
  assign resp_valid  = resp_valid_q;
  assign resp_err    = resp_err_q;
  assign resp_rdata  = resp_rdata_q;
  assign dbg_state_o = state_q;

  always_comb begin
    acc_err = 1'b0;
    if (req_funct3 == 3'b011 || req_funct3 == 3'b110 || req_funct3 == 3'b111) acc_err = 1'b1;
    if (req_we && req_funct3 > 3'b010) acc_err = 1'b1;
    if (req_funct3[1:0] == 2'b01 && req_addr[0]) acc_err = 1'b1;
    if (req_funct3 == 3'b010 && req_addr[1:0] != 2'b00) acc_err = 1'b1;
    if (req_addr[31:2] >= MEM_WORDS_W) acc_err = 1'b1;
  end

  always_comb begin
    logic [7:0]  lane_b;
    logic [15:0] lane_h;
    lane_b = rdata[{addr_q[1:0], 3'b000} +: 8];
    lane_h = rdata[{addr_q[1], 4'b0000} +: 16];
    unique case (f3_q)
      3'b000:  load_ext = {{24{lane_b[7]}}, lane_b};
      3'b100:  load_ext = {24'd0, lane_b};
      3'b001:  load_ext = {{16{lane_h[15]}}, lane_h};
      3'b101:  load_ext = {16'd0, lane_h};
      default: load_ext = rdata;
    endcase
  end

  // Merge uses only the word read during RMW_RD; other lanes pass through untouched.
  always_comb begin
    merged = rdata;
    if (f3_q[1:0] == 2'b00) merged[{addr_q[1:0], 3'b000} +: 8] = st_q[7:0];
    else                    merged[{addr_q[1], 4'b0000} +: 16] = st_q;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE: begin
        if (req_valid) begin
          if (acc_err)                          state_d = ERR;
          else if (!req_we)                     state_d = LD_RD;
          else if (req_funct3 == 3'b010)        state_d = WR;
          else                                  state_d = RMW_RD;
        end
      end
      LD_RD:   state_d = LD_EXT;
      LD_EXT:  state_d = IDLE;
      RMW_RD:  state_d = RMW_MRG;
      RMW_MRG: state_d = WR;
      WR:      state_d = IDLE;
      ERR:     state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    addr_nx       = addr_q;
    wdata_nx      = wdata_q;
    wen_nx        = 1'b0;
    resp_valid_nx = 1'b0;
    resp_err_nx   = 1'b0;
    resp_rdata_nx = resp_rdata_q;
    f3_d          = f3_q;
    st_d          = st_q;
    unique case (state_q)
      IDLE: begin
        if (req_valid) begin
          f3_d = req_funct3;
          st_d = req_wdata[15:0];
          if (!acc_err) begin
            addr_nx = req_addr;
            if (req_we && req_funct3 == 3'b010) begin
              wdata_nx = req_wdata;
              wen_nx   = 1'b1;
            end
          end
        end
      end
      LD_EXT: begin
        resp_rdata_nx = load_ext;
        resp_valid_nx = 1'b1;
      end
      RMW_MRG: begin
        wdata_nx = merged;
        wen_nx   = 1'b1;
      end
      WR: begin
        resp_rdata_nx = 32'd0;
        resp_valid_nx = 1'b1;
      end
      ERR: begin
        resp_rdata_nx = 32'd0;
        resp_valid_nx = 1'b1;
        resp_err_nx   = 1'b1;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      addr_q       <= 32'd0;
      wdata_q      <= 32'd0;
      wen_q        <= 1'b0;
      resp_valid_q <= 1'b0;
      resp_err_q   <= 1'b0;
      resp_rdata_q <= 32'd0;
      f3_q         <= 3'd0;
      st_q         <= 16'd0;
    end else begin
      addr_q       <= addr_nx;
      wdata_q      <= wdata_nx;
      wen_q        <= wen_nx;
      resp_valid_q <= resp_valid_nx;
      resp_err_q   <= resp_err_nx;
      resp_rdata_q <= resp_rdata_nx;
      f3_q         <= f3_d;
      st_q         <= st_d;
    end
  end

endmodule

// File: tb/tb_dmem_access_unit.sv
// Bench for dmem_access_unit: behavioural word memory, directed accesses, and a
// scoreboard that checks every response and every memory write pulse.
module tb_dmem_access_unit;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic        req_we = 1'b0;
  logic [2:0]  req_funct3 = 3'd0;
  logic [31:0] req_addr = 32'd0;
  logic [31:0] req_wdata = 32'd0;
  logic        resp_valid;
  logic [31:0] resp_rdata;
  logic        resp_err;
  logic [31:0] addr_d;
  logic [31:0] rdata;
  logic        wen;
  logic [31:0] wdata;
  logic [2:0]  dbg_state;

  localparam logic [2:0] S_IDLE = 3'd0, S_RMW_RD = 3'd3, S_RMW_MRG = 3'd4;

  int n_checks = 0;
  int n_fail   = 0;

  logic [32:0] exp_q[$];
  string       exp_name_q[$];
  logic [63:0] exp_wq[$];

  // preload port into the memory model so only one process writes mem
  logic        pre_we = 1'b0;
  logic [5:0]  pre_idx = 6'd0;
  logic [31:0] pre_val = 32'd0;
  logic [31:0] mem [0:63];

  always #5 clk = ~clk;

  dmem_access_unit #(.MEM_WORDS(4096)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
    .req_funct3(req_funct3), .req_addr(req_addr), .req_wdata(req_wdata),
    .resp_valid(resp_valid), .resp_rdata(resp_rdata), .resp_err(resp_err),
    .addr_d(addr_d), .rdata(rdata), .wen(wen), .wdata(wdata),
    .dbg_state_o(dbg_state)
  );

  always @(posedge clk) begin
    rdata <= mem[addr_d[7:2]];
    if (wen) mem[addr_d[7:2]] <= wdata;
    else if (pre_we) mem[pre_idx] <= pre_val;
  end

  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  // monitor: pops the scoreboard whenever the DUT responds or writes memory
  always @(negedge clk) begin
    if (resp_valid) begin
      if (exp_q.size() == 0) check("unexpected resp_valid", 64'd1, 64'd0);
      else begin
        logic [32:0] e;
        string nm;
        e  = exp_q.pop_front();
        nm = exp_name_q.pop_front();
        check({nm, " resp"}, {31'd0, resp_err, resp_rdata}, {31'd0, e});
      end
    end
    if (wen) begin
      if (exp_wq.size() == 0) check("unexpected wen", {32'd0, wdata}, 64'd0);
      else check("mem write", {addr_d & 32'hFFFF_FFFC, wdata}, exp_wq.pop_front());
    end
  end

  task automatic preload(input logic [5:0] idx, input logic [31:0] val);
    @(negedge clk);
    pre_we = 1'b1; pre_idx = idx; pre_val = val;
    @(negedge clk);
    pre_we = 1'b0;
  endtask

  task automatic wait_ready(input string nm);
    int k;
    k = 0;
    while (!req_ready && k < 20) begin
      @(negedge clk);
      k++;
    end
    check({nm, " ready"}, {63'd0, req_ready}, 64'd1);
  endtask

  task automatic access(input string nm, input logic we, input logic [2:0] f3,
                        input logic [31:0] addr, input logic [31:0] wd,
                        input logic exp_err, input logic [31:0] exp_rd, input int exp_lat,
                        input logic exp_wr, input logic [31:0] exp_wd);
    int lat, wen_at;
    logic got;
    wait_ready(nm);
    exp_q.push_back({exp_err, exp_rd});
    exp_name_q.push_back(nm);
    if (exp_wr) exp_wq.push_back({addr & 32'hFFFF_FFFC, exp_wd});
    req_valid = 1'b1; req_we = we; req_funct3 = f3; req_addr = addr; req_wdata = wd;
    @(posedge clk);
    lat = 0; wen_at = -1; got = 1'b0;
    for (int n = 1; n <= 20 && !got; n++) begin
      @(negedge clk);
      if (n == 1) begin
        req_valid  = 1'b0;
        req_we     = 1'($urandom_range(0, 1));
        req_funct3 = 3'($urandom_range(0, 7));
        req_addr   = $urandom;
        req_wdata  = $urandom;
      end
      if (wen && wen_at < 0) wen_at = n;
      if (resp_valid) begin
        got = 1'b1;
        lat = n;
      end
    end
    check({nm, " latency"}, 64'(lat), 64'(exp_lat));
    check({nm, " wen cycle"}, 64'(wen_at), exp_wr ? 64'(exp_lat - 1) : 64'(-1));
  endtask

  task automatic check_reset_outputs(input string nm);
    check({nm, " ready"},  {63'd0, req_ready}, 64'd1);
    check({nm, " state"},  {61'd0, dbg_state}, {61'd0, S_IDLE});
    check({nm, " ctrl"},   {61'd0, wen, resp_valid, resp_err}, 64'd0);
    check({nm, " addr_d"}, {32'd0, addr_d}, 64'd0);
    check({nm, " wdata"},  {32'd0, wdata}, 64'd0);
    check({nm, " rdata"},  {32'd0, resp_rdata}, 64'd0);
  endtask

  initial begin
    repeat (3) @(negedge clk);
    check_reset_outputs("reset");
    rst_n = 1'b1;
    preload(6'd4, 32'h8081_82F3);
    preload(6'd2, 32'h1122_3344);
    preload(6'd63, 32'h5A5A_1234);

    // loads: lane select and extension
    access("LB 0x13",  1'b0, 3'b000, 32'h13, 32'h0, 1'b0, 32'hFFFF_FF80, 3, 1'b0, 32'h0);
    access("LBU 0x13", 1'b0, 3'b100, 32'h13, 32'h0, 1'b0, 32'h0000_0080, 3, 1'b0, 32'h0);
    access("LB 0x10",  1'b0, 3'b000, 32'h10, 32'h0, 1'b0, 32'hFFFF_FFF3, 3, 1'b0, 32'h0);
    access("LB 0x11",  1'b0, 3'b000, 32'h11, 32'h0, 1'b0, 32'hFFFF_FF82, 3, 1'b0, 32'h0);
    access("LBU 0x12", 1'b0, 3'b100, 32'h12, 32'h0, 1'b0, 32'h0000_0081, 3, 1'b0, 32'h0);
    access("LH 0x12",  1'b0, 3'b001, 32'h12, 32'h0, 1'b0, 32'hFFFF_8081, 3, 1'b0, 32'h0);
    access("LHU 0x10", 1'b0, 3'b101, 32'h10, 32'h0, 1'b0, 32'h0000_82F3, 3, 1'b0, 32'h0);
    access("LW 0x10",  1'b0, 3'b010, 32'h10, 32'h0, 1'b0, 32'h8081_82F3, 3, 1'b0, 32'h0);
    access("LW 0x3FFC", 1'b0, 3'b010, 32'h3FFC, 32'h0, 1'b0, 32'h5A5A_1234, 3, 1'b0, 32'h0);

    // sub-word stores via read-modify-write; upper wdata bits must be ignored
    access("SB 0x09", 1'b1, 3'b000, 32'h09, 32'h1234_56AB, 1'b0, 32'h0, 4, 1'b1, 32'h1122_AB44);
    access("SH 0x0A", 1'b1, 3'b001, 32'h0A, 32'hCAFE_BEEF, 1'b0, 32'h0, 4, 1'b1, 32'hBEEF_AB44);
    access("LW 0x08", 1'b0, 3'b010, 32'h08, 32'h0, 1'b0, 32'hBEEF_AB44, 3, 1'b0, 32'h0);

    // full-word store
    access("SW 0x20",  1'b1, 3'b010, 32'h20, 32'hDEAD_BEEF, 1'b0, 32'h0, 2, 1'b1, 32'hDEAD_BEEF);
    access("LW 0x20",  1'b0, 3'b010, 32'h20, 32'h0, 1'b0, 32'hDEAD_BEEF, 3, 1'b0, 32'h0);
    access("LH 0x22",  1'b0, 3'b001, 32'h22, 32'h0, 1'b0, 32'hFFFF_DEAD, 3, 1'b0, 32'h0);
    access("LHU 0x20", 1'b0, 3'b101, 32'h20, 32'h0, 1'b0, 32'h0000_BEEF, 3, 1'b0, 32'h0);

    // error cases: no memory write, zero data
    access("err LW 0x22",   1'b0, 3'b010, 32'h22,   32'h0, 1'b1, 32'h0, 2, 1'b0, 32'h0);
    access("err SH 0x11",   1'b1, 3'b001, 32'h11,   32'hFFFF, 1'b1, 32'h0, 2, 1'b0, 32'h0);
    access("err f3 011",    1'b0, 3'b011, 32'h10,   32'h0, 1'b1, 32'h0, 2, 1'b0, 32'h0);
    access("err LW 0x4000", 1'b0, 3'b010, 32'h4000, 32'h0, 1'b1, 32'h0, 2, 1'b0, 32'h0);
    access("err store f3 100", 1'b1, 3'b100, 32'h10, 32'h55, 1'b1, 32'h0, 2, 1'b0, 32'h0);
    access("err LW 0x0F", 1'b0, 3'b010, 32'h0F, 32'h0, 1'b1, 32'h0, 2, 1'b0, 32'h0);

    // reset during RMW_MRG drops the pending write
    wait_ready("SB abort");
    req_valid = 1'b1; req_we = 1'b1; req_funct3 = 3'b000; req_addr = 32'h08; req_wdata = 32'h77;
    @(posedge clk);
    @(negedge clk);
    req_valid = 1'b0;
    check("SB abort state1", {61'd0, dbg_state}, {61'd0, S_RMW_RD});
    @(negedge clk);
    check("SB abort state2", {61'd0, dbg_state}, {61'd0, S_RMW_MRG});
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    check_reset_outputs("abort reset");
    rst_n = 1'b1;
    @(negedge clk);
    check("abort ready after release", {63'd0, req_ready}, 64'd1);
    access("LW 0x08 after abort", 1'b0, 3'b010, 32'h08, 32'h0, 1'b0, 32'hBEEF_AB44, 3, 1'b0, 32'h0);

    repeat (4) @(negedge clk);
    check("resp queue drained", 64'(exp_q.size()), 64'd0);
    check("write queue drained", 64'(exp_wq.size()), 64'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
